vc_dest_arbiter: RTL and testbench
==================================

// Module: vc_dest_arbiter
// PURPOSE
// Master controller of the PCIe transaction datapath. Drains the two virtual-channel FIFOs (VC0, VC1) into the
// two destination FIFOs (D0, D1), one word per cycle, routed by the word's destination bit. Applies VC0 priority
// with an anti-starvation burst limit and backpressures on destination almost-full thresholds. Runs the
// RESET/INIT/IDLE/ACTIVE/ERROR FSM, and latches and distributes the FIFO thresholds.
// PARAMETERS
// DATA_W        6   word width; [DATA_W-1]=VC bit, [DATA_W-2]=destination bit (0=D0,1=D1), rest payload
// VC_UMB_W      4   VC threshold width
// D_UMB_W       2   destination threshold width; destination counts are D_UMB_W+1 bits
// VC_UMB_RST    12  reset value of latched VC thresholds
// D_UMB_RST     3   reset value of latched destination thresholds
// MAX_VC0_BURST 4   consecutive VC0 grants allowed while VC1 is eligible before VC1 is forced (>=1)
// PORTS
// clk             in  1          clock, all logic on posedge
// reset_L         in  1          synchronous active-low reset
// init            in  1          request (re)load of thresholds
// umbral_vc0/vc1  in  VC_UMB_W   VC almost-full thresholds to latch
// umbral_d0/d1    in  D_UMB_W    destination almost-full thresholds to latch
// umbral_vc0_q/vc1_q out VC_UMB_W latched VC thresholds, to the VC FIFOs
// umbral_d0_q/d1_q   out D_UMB_W  latched destination thresholds, to the D FIFOs
// vc0_empty/vc1_empty in 1       VC FIFO empty; the FIFOs are show-ahead
// vc0_data/vc1_data   in DATA_W  VC FIFO head word, valid when !empty
// vc0_pop/vc1_pop     out 1      combinational pop, removes head at this edge
// d0_count/d1_count   in D_UMB_W+1 destination FIFO fill level
// d0_empty/d1_empty   in 1       destination FIFO empty
// d0_push/d1_push     out 1      registered push into the destination FIFO
// d_data          out DATA_W     registered word for d0_push/d1_push
// err_in          in  4          FIFO over/underflow flags {d1,d0,vc1,vc0}
// active_out/idle_out/error_out out 1  registered state flags
// BEHAVIOUR
// - reset_L=0 at an edge: state=RESET; every registered output=0; *_q=*_RST; burst counter=0. Pops gated to 0
//   combinationally while reset_L=0.
// - FSM: RESET->INIT on the first edge with reset_L=1.
//   INIT: latch umbral_* into *_q each cycle; ->IDLE when init=0. INIT lasts at least 1 cycle.
//   IDLE (idle_out=1): ->INIT if init; ->ERROR if |err_in; ->ACTIVE if !vc0_empty|!vc1_empty.
//   ACTIVE (active_out=1): ->ERROR if |err_in; ->INIT if init and no push pending;
//   ->IDLE when all 4 FIFOs are empty and no push is pending.
//   ERROR (error_out=1): sticky; pops/pushes=0; init ignored; exits only through reset. Priority: err > init > rest.
// - Grants only in ACTIVE. VCk is eligible if !vck_empty and, for dest X=vck_data[DATA_W-2],
//   (dX_count + dX_push) < umbral_dX_q. The in-flight word is counted; a threshold of 0 blocks X.
// - Arbitration: VC0 wins unless burst counter==MAX_VC0_BURST and VC1 is eligible, in which case VC1 wins and
//   the counter clears. Counter increments on a VC0 grant while VC1 is eligible and clears on a VC1 grant or when
//   VC1 is not eligible. At most one pop per cycle.
// - Latency: pop at edge N -> dX_push=1 and d_data=head word at edge N+1 (1 cycle); d0_push and d1_push are never
//   both 1. Pushes are 0 when no grant occurred.
// - Entering ERROR or RESET cancels the pending push at that same edge.
// TESTING
// T1 reset_L=0 x2, then 1 with init=0, umbral_d0=2 -> RESET, INIT 1 cycle, IDLE; idle_out=1, umbral_d0_q=2.
// T2 vc0 head 6'b011011, vc1 empty -> vc0_pop=1 same cycle; next cycle d1_push=1, d_data=6'b011011; then IDLE.
// T3 both VCs always hold D0 words, counts 0, MAX_VC0_BURST=4 -> grant pattern VC0,VC0,VC0,VC0,VC1 repeating.
// T4 umbral_d0_q=2, d0_count=1, d0_push=1; vc0 head->D0, vc1 head->D1 -> vc0_pop=0, vc1_pop=1.
// T5 ACTIVE, err_in=4'b0100 -> next cycle error_out=1, pops=0; held with init=1; cleared only by reset_L=0.
// T6 reset_L=0 in the cycle after a pop -> d0_push/d1_push=0 at that edge; no word pushed after release.

Source files
------------

// File: rtl/vc_dest_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vc_dest_arbiter
// Purpose  : Drains VC0/VC1 FIFOs into D0/D1 with VC0 priority, a VC0 burst
//            limit, destination backpressure and the RESET/INIT/IDLE/ACTIVE/
//            ERROR controller that also holds the latched FIFO thresholds.
// Revision : 1.0 - initial release
// ============================================================================
module vc_dest_arbiter #(
    parameter int DATA_W        = 6,
    parameter int VC_UMB_W      = 4,
    parameter int D_UMB_W       = 2,
    parameter int VC_UMB_RST    = 12,
    parameter int D_UMB_RST     = 3,
    parameter int MAX_VC0_BURST = 4
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [VC_UMB_W-1:0] umbral_vc0,
    input  logic [VC_UMB_W-1:0] umbral_vc1,
    input  logic [D_UMB_W-1:0]  umbral_d0,
    input  logic [D_UMB_W-1:0]  umbral_d1,
    output logic [VC_UMB_W-1:0] umbral_vc0_q,
    output logic [VC_UMB_W-1:0] umbral_vc1_q,
    output logic [D_UMB_W-1:0]  umbral_d0_q,
    output logic [D_UMB_W-1:0]  umbral_d1_q,
    input  logic                vc0_empty,
    input  logic                vc1_empty,
    input  logic [DATA_W-1:0]   vc0_data,
    input  logic [DATA_W-1:0]   vc1_data,
    output logic                vc0_pop,
    output logic                vc1_pop,
    input  logic [D_UMB_W:0]    d0_count,
    input  logic [D_UMB_W:0]    d1_count,
    input  logic                d0_empty,
    input  logic                d1_empty,
    output logic                d0_push,
    output logic                d1_push,
    output logic [DATA_W-1:0]   d_data,
    input  logic [3:0]          err_in,
    output logic                active_out,
    output logic                idle_out,
    output logic                error_out
);

    localparam int c_BURST_W = $clog2(MAX_VC0_BURST + 1);
    localparam int c_LVL_W   = D_UMB_W + 2;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_BURST_W-1:0]  r_burst;
    logic [c_BURST_W-1:0]  w_burst_nxt;
    logic                  r_d0_push;
    logic                  r_d1_push;
    logic [DATA_W-1:0]     r_d_data;
    logic                  r_active;
    logic                  r_idle;
    logic                  r_error;
    logic [VC_UMB_W-1:0]   r_umb_vc0;
    logic [VC_UMB_W-1:0]   r_umb_vc1;
    logic [D_UMB_W-1:0]    r_umb_d0;
    logic [D_UMB_W-1:0]    r_umb_d1;

    logic                  w_err;
    logic                  w_pend;
    logic                  w_room0;
    logic                  w_room1;
    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_grant_en;
    logic                  w_grant0;
    logic                  w_grant1;
    logic [c_LVL_W-1:0]    w_lvl0;
    logic [c_LVL_W-1:0]    w_lvl1;

    assign w_err  = |err_in;
    assign w_pend = r_d0_push | r_d1_push;

    // The word already in flight to a destination counts against its room.
    assign w_lvl0  = c_LVL_W'(d0_count) + c_LVL_W'(r_d0_push);
    assign w_lvl1  = c_LVL_W'(d1_count) + c_LVL_W'(r_d1_push);
    assign w_room0 = w_lvl0 < c_LVL_W'(r_umb_d0);
    assign w_room1 = w_lvl1 < c_LVL_W'(r_umb_d1);

    assign w_elig0 = !vc0_empty && (vc0_data[DATA_W-2] ? w_room1 : w_room0);
    assign w_elig1 = !vc1_empty && (vc1_data[DATA_W-2] ? w_room1 : w_room0);

    // No new grants while leaving ACTIVE, so no popped word is ever dropped.
    assign w_grant_en = reset_L && (r_state == S_ACTIVE) && !w_err && !init;

    always_comb begin
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_burst_nxt = r_burst;
        if (w_grant_en) begin
            if (w_elig1 && (r_burst == c_BURST_W'(MAX_VC0_BURST))) begin
                w_grant1    = 1'b1;
                w_burst_nxt = '0;
            end else if (w_elig0) begin
                w_grant0    = 1'b1;
                w_burst_nxt = w_elig1 ? r_burst + c_BURST_W'(1) : '0;
            end else if (w_elig1) begin
                w_grant1    = 1'b1;
                w_burst_nxt = '0;
            end else begin
                w_burst_nxt = '0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:  w_next = S_INIT;
            S_INIT:   if (!init) w_next = S_IDLE;
            S_IDLE: begin
                if (w_err)                        w_next = S_ERROR;
                else if (init)                    w_next = S_INIT;
                else if (!vc0_empty || !vc1_empty) w_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_err)
                    w_next = S_ERROR;
                else if (init && !w_pend)
                    w_next = S_INIT;
                else if (vc0_empty && vc1_empty && d0_empty && d1_empty && !w_pend)
                    w_next = S_IDLE;
            end
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state   <= S_RESET;
            r_burst   <= '0;
            r_d0_push <= 1'b0;
            r_d1_push <= 1'b0;
            r_d_data  <= '0;
            r_active  <= 1'b0;
            r_idle    <= 1'b0;
            r_error   <= 1'b0;
            r_umb_vc0 <= VC_UMB_W'(VC_UMB_RST);
            r_umb_vc1 <= VC_UMB_W'(VC_UMB_RST);
            r_umb_d0  <= D_UMB_W'(D_UMB_RST);
            r_umb_d1  <= D_UMB_W'(D_UMB_RST);
        end else begin
            r_state   <= w_next;
            r_burst   <= w_burst_nxt;
            r_d0_push <= (w_grant0 && !vc0_data[DATA_W-2]) || (w_grant1 && !vc1_data[DATA_W-2]);
            r_d1_push <= (w_grant0 &&  vc0_data[DATA_W-2]) || (w_grant1 &&  vc1_data[DATA_W-2]);
            if (w_grant0)
                r_d_data <= vc0_data;
            else if (w_grant1)
                r_d_data <= vc1_data;
            r_active  <= (w_next == S_ACTIVE);
            r_idle    <= (w_next == S_IDLE);
            r_error   <= (w_next == S_ERROR);
            if (r_state == S_INIT) begin
                r_umb_vc0 <= umbral_vc0;
                r_umb_vc1 <= umbral_vc1;
                r_umb_d0  <= umbral_d0;
                r_umb_d1  <= umbral_d1;
            end
        end
    end

    assign vc0_pop      = w_grant0;
    assign vc1_pop      = w_grant1;
    assign d0_push      = r_d0_push;
    assign d1_push      = r_d1_push;
    assign d_data       = r_d_data;
    assign active_out   = r_active;
    assign idle_out     = r_idle;
    assign error_out    = r_error;
    assign umbral_vc0_q = r_umb_vc0;
    assign umbral_vc1_q = r_umb_vc1;
    assign umbral_d0_q  = r_umb_d0;
    assign umbral_d1_q  = r_umb_d1;

endmodule
`default_nettype wire

// File: tb/tb_vc_dest_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_dest_arbiter
// Purpose  : Directed self-checking bench for vc_dest_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_dest_arbiter;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic [3:0] umbral_vc0, umbral_vc1, umbral_vc0_q, umbral_vc1_q;
    logic [1:0] umbral_d0, umbral_d1, umbral_d0_q, umbral_d1_q;
    logic       vc0_empty, vc1_empty, vc0_pop, vc1_pop;
    logic [5:0] vc0_data, vc1_data, d_data;
    logic [2:0] d0_count, d1_count;
    logic       d0_empty, d1_empty, d0_push, d1_push;
    logic [3:0] err_in;
    logic       active_out, idle_out, error_out;

    int checks = 0;
    int errors = 0;

    vc_dest_arbiter dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_vc0(umbral_vc0), .umbral_vc1(umbral_vc1),
        .umbral_d0(umbral_d0), .umbral_d1(umbral_d1),
        .umbral_vc0_q(umbral_vc0_q), .umbral_vc1_q(umbral_vc1_q),
        .umbral_d0_q(umbral_d0_q), .umbral_d1_q(umbral_d1_q),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
        .d0_count(d0_count), .d1_count(d1_count),
        .d0_empty(d0_empty), .d1_empty(d1_empty),
        .d0_push(d0_push), .d1_push(d1_push), .d_data(d_data),
        .err_in(err_in),
        .active_out(active_out), .idle_out(idle_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp1;
        logic prev1;
        reset_L = 1'b0; init = 1'b0;
        umbral_vc0 = 4'd5; umbral_vc1 = 4'd6; umbral_d0 = 2'd2; umbral_d1 = 2'd3;
        vc0_empty = 1'b1; vc1_empty = 1'b1; vc0_data = '0; vc1_data = '0;
        d0_count = '0; d1_count = '0; d0_empty = 1'b1; d1_empty = 1'b1; err_in = '0;

        // T1: reset, single INIT cycle, IDLE with latched thresholds
        tick(); tick();
        check("rst_idle", idle_out, 0);
        check("rst_active", active_out, 0);
        check("rst_error", error_out, 0);
        check("rst_push", {d0_push, d1_push}, 0);
        check("rst_umb_d0", umbral_d0_q, 3);
        check("rst_umb_vc0", umbral_vc0_q, 12);
        reset_L = 1'b1;
        tick();
        check("init_idle", idle_out, 0);
        check("init_umb_d0", umbral_d0_q, 3);
        tick();
        check("t1_idle", idle_out, 1);
        check("t1_umb_d0", umbral_d0_q, 2);
        check("t1_umb_vc1", umbral_vc1_q, 6);
        check("t1_umb_d1", umbral_d1_q, 3);

        // T2: single VC0 word to D1
        vc0_empty = 1'b0; vc0_data = 6'b011011;
        settle();
        check("t2_idle_nopop", vc0_pop, 0);
        tick();
        check("t2_active", active_out, 1);
        check("t2_pop0", vc0_pop, 1);
        check("t2_pop1", vc1_pop, 0);
        tick();
        vc0_empty = 1'b1;
        settle();
        check("t2_d1_push", d1_push, 1);
        check("t2_d0_push", d0_push, 0);
        check("t2_data", d_data, 6'b011011);
        check("t2_nopop", vc0_pop, 0);
        tick();
        check("t2_push_done", d1_push, 0);
        check("t2_still_active", active_out, 1);
        tick();
        check("t2_back_idle", idle_out, 1);

        // T3: reload d0 threshold to 3, then 4:1 burst pattern
        init = 1'b1; umbral_d0 = 2'd3;
        tick();
        init = 1'b0;
        tick();
        check("t3_idle", idle_out, 1);
        check("t3_umb_d0", umbral_d0_q, 3);
        vc0_empty = 1'b0; vc0_data = 6'b000001;
        vc1_empty = 1'b0; vc1_data = 6'b100010;
        tick();
        prev1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp1 = ((i % 5) == 4);
            settle();
            check($sformatf("t3_pop0_%0d", i), vc0_pop, !exp1);
            check($sformatf("t3_pop1_%0d", i), vc1_pop, exp1);
            if (i >= 1) begin
                check($sformatf("t3_push_%0d", i), {d0_push, d1_push}, 2'b10);
                check($sformatf("t3_data_%0d", i), d_data, prev1 ? 6'b100010 : 6'b000001);
            end
            prev1 = exp1;
            tick();
        end

        // Leave ACTIVE through INIT to load d0 threshold 2
        init = 1'b1; umbral_d0 = 2'd2;
        settle();
        check("init_gates_pop", {vc0_pop, vc1_pop}, 0);
        tick();
        check("init_wait_pend", active_out, 1);
        tick();
        init = 1'b0;
        d0_count = 3'd1;
        vc0_data = 6'b001010; vc1_data = 6'b110101;
        tick();
        check("t4_idle", idle_out, 1);
        check("t4_umb_d0", umbral_d0_q, 2);

        // T4: in-flight D0 word blocks VC0, VC1 to D1 proceeds
        tick();
        check("t4_first_pop0", vc0_pop, 1);
        check("t4_first_pop1", vc1_pop, 0);
        tick();
        check("t4_d0_push", d0_push, 1);
        check("t4_block_pop0", vc0_pop, 0);
        check("t4_pop1", vc1_pop, 1);
        tick();
        check("t4_d1_push", d1_push, 1);
        check("t4_d1_data", d_data, 6'b110101);
        check("t4_d0_idle", d0_push, 0);

        // T5: error is sticky and ignores init
        err_in = 4'b0100;
        settle();
        check("t5_err_gate", {vc0_pop, vc1_pop}, 0);
        tick();
        err_in = 4'b0000; init = 1'b1;
        settle();
        check("t5_error", error_out, 1);
        check("t5_active", active_out, 0);
        check("t5_pops", {vc0_pop, vc1_pop}, 0);
        check("t5_push", {d0_push, d1_push}, 0);
        tick(); tick();
        check("t5_sticky", error_out, 1);
        check("t5_not_idle", idle_out, 0);
        check("t5_pops2", {vc0_pop, vc1_pop}, 0);
        reset_L = 1'b0;
        tick();
        check("t5_cleared", error_out, 0);

        // T6: reset during a pop cycle cancels the push
        reset_L = 1'b1; init = 1'b0;
        tick(); tick();
        check("t6_idle", idle_out, 1);
        tick();
        check("t6_pop", vc0_pop, 1);
        reset_L = 1'b0;
        settle();
        check("t6_pop_gated", {vc0_pop, vc1_pop}, 0);
        tick();
        check("t6_push_cancel", {d0_push, d1_push}, 0);
        check("t6_flags", {active_out, idle_out, error_out}, 0);
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        reset_L = 1'b1;
        tick();
        check("t6_init_push", {d0_push, d1_push}, 0);
        tick();
        check("t6_idle_push", {d0_push, d1_push}, 0);
        check("t6_idle_again", idle_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
